counter_preload_loader: RTL and testbench
=========================================

COUNTER_PRELOAD_LOADER -- requirements
Module: counter_preload_loader

Interface
REQ-001 Parameter SYNC_STAGES, default 2: flip-flop depth of each pin synchroniser; legal range 2..4.
REQ-002 clk  input  1  single clock; all state on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-high (asserted when 1).
REQ-004 cs_n_in  input  1  serial frame select from pin, active-low, asynchronous to clk.
REQ-005 sclk_in  input  1  serial bit clock from pin, asynchronous to clk; data captured on its rising edge.
REQ-006 sdata_in  input  1  serial data from pin, MSB first.
REQ-007 load_data  output  8  assembled preload value for the downstream counter's data input.
REQ-008 load_valid  output  1  load_data holds a complete, checked value.
REQ-009 load_ready  input  1  downstream accepts load_data when load_valid && load_ready.
REQ-010 busy  output  1  high in SHIFT and HOLD.
REQ-011 frame_err  output  1  one-cycle pulse on a rejected frame.

Function
REQ-012 cs_n_in, sclk_in, sdata_in each pass through a SYNC_STAGES-deep synchroniser (cs_n_s, sclk_s, sdata_s); cs_n and sclk synchronisers reset to 1, sdata to 0.
REQ-013 Edges are detected on synchronised signals only: sclk rise = sclk_s 0->1, cs fall/rise = cs_n_s 1->0 / 0->1.
REQ-014 States: IDLE, SHIFT, HOLD; reset state IDLE.
REQ-015 IDLE: on cs fall -> SHIFT, bit_cnt=0, ovr flag cleared; all other events ignored.
REQ-016 SHIFT: each sclk rise shifts sdata_s into shift register LSB side (MSB first overall), bit_cnt+1; bit_cnt saturates at FRAME_BITS, an sclk rise at saturation sets ovr.
REQ-017 FRAME_BITS = 8, or 9 when LOADER_PARITY_EN defined.
REQ-018 SHIFT, cs rise: bit_cnt==FRAME_BITS and ovr==0 (and parity ok if enabled) -> HOLD, load_data = first 8 bits received; otherwise frame_err=1 for one cycle -> IDLE, load_data unchanged.
REQ-019 sclk rise and cs rise in the same cycle: cs rise wins, that sclk rise is discarded.
REQ-020 HOLD: load_valid=1, load_data stable; serial activity ignored; frame starting during HOLD is lost (detected only by cs fall seen in IDLE).
REQ-021 HOLD with load_ready=1: transfer completes that edge, next cycle IDLE, load_valid=0.
REQ-022 Latency: load_valid rises the cycle after the cs rise is detected (1 cycle after cs_n_s goes high); overall pin-to-valid = SYNC_STAGES+1 cycles.
REQ-023 load_ready has no effect outside HOLD; load_valid never depends combinationally on load_ready.

Reset
REQ-024 rst_n=1 at a clock edge: state IDLE, load_data=8'h00, load_valid=0, busy=0, frame_err=0, bit_cnt=0, ovr=0, shift register=0.
REQ-025 Reset mid-frame or in HOLD aborts without frame_err; after release a frame is accepted only after a fresh cs fall (cs held low across reset is not a frame start).

Configuration
REQ-026 Macro LOADER_PARITY_EN defined: 9th bit is odd parity over the 8 data bits; mismatch at cs rise -> frame_err, no HOLD.
REQ-027 LOADER_PARITY_EN undefined: no parity logic; frame is exactly 8 bits, a 9th sclk rise sets ovr.

Verification
REQ-028 Frame 8'hA5 (no parity), load_ready=1 -> load_valid one cycle, load_data=8'hA5, frame_err=0, busy then 0.
REQ-029 Frame 8'h3C, load_ready=0 for 10 cycles then 1 -> load_valid held 11 cycles with 8'h3C stable, second frame sent during HOLD is dropped.
REQ-030 Frame of 7 bits, then 9 bits (parity off) -> two frame_err pulses, load_valid never asserted, load_data keeps previous value.
REQ-031 sclk rise coincident with cs rise after 8 bits of 8'hFF -> accepted as 8'hFF, extra edge discarded.
REQ-032 rst_n pulsed after 4 bits of a frame, cs held low -> no frame_err, no load_valid; next full frame 8'h01 accepted.
REQ-033 LOADER_PARITY_EN: 8'h07 + parity 0 accepted; 8'h07 + parity 1 -> frame_err, no load_valid.

Source files
------------

// File: rtl/counter_preload_loader_if.sv
// Preload handshake bundle between the serial loader (master) and the
// downstream counter (slave).
interface counter_preload_loader_if;
  logic [7:0] load_data;
  logic       load_valid;
  logic       load_ready;
  logic       busy;
  logic       frame_err;

  modport master (
    output load_data,
    output load_valid,
    input  load_ready,
    output busy,
    output frame_err
  );

  modport slave (
    input  load_data,
    input  load_valid,
    output load_ready,
    input  busy,
    input  frame_err
  );
endinterface

// File: rtl/counter_preload_loader.sv
// Serial-pin preload loader: synchronises cs_n/sclk/sdata, assembles an 8-bit
// value and holds it for the counter. Optional macro LOADER_PARITY_EN adds an odd-parity 9th bit.
module counter_preload_loader #(
  parameter int SYNC_STAGES = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            cs_n_in,
  input  logic                            sclk_in,
  input  logic                            sdata_in,
  counter_preload_loader_if.master        load_bus
);

`ifdef LOADER_PARITY_EN
  localparam int FRAME_BITS = 9;
`else
  localparam int FRAME_BITS = 8;
`endif
  localparam logic [3:0] FRAME_BITS_C = 4'(FRAME_BITS);
  localparam logic [2:0] SETTLE_DONE  = 3'(SYNC_STAGES + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

`ifdef LOADER_PARITY_EN
  function automatic logic odd_parity_ok(input logic [8:0] frame);
    return ^frame;
  endfunction
`endif

  logic [SYNC_STAGES-1:0] cs_n_sync_r;
  logic [SYNC_STAGES-1:0] sclk_sync_r;
  logic [SYNC_STAGES-1:0] sdata_sync_r;
  logic                   cs_n_s;
  logic                   sclk_s;
  logic                   sdata_s;
  logic                   cs_n_prev_r;
  logic                   sclk_prev_r;
  logic [2:0]             settle_r;
  logic                   settled_s;
  logic                   cs_fall_s;
  logic                   cs_rise_s;
  logic                   sclk_rise_s;
  logic                   frame_ok_s;
  logic [1:0]             state_r;
  logic [1:0]             state_nx;
  logic [3:0]             bit_cnt_r;
  logic                   ovr_r;
  logic [FRAME_BITS-1:0]  shift_r;
  logic [7:0]             load_data_r;
  logic                   load_valid_r;
  logic                   busy_r;
  logic                   frame_err_r;

  assign cs_n_s  = cs_n_sync_r[SYNC_STAGES-1];
  assign sclk_s  = sclk_sync_r[SYNC_STAGES-1];
  assign sdata_s = sdata_sync_r[SYNC_STAGES-1];

  // Pin synchronisers, edge history and post-reset settle counter.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      cs_n_sync_r  <= {SYNC_STAGES{1'b1}};
      sclk_sync_r  <= {SYNC_STAGES{1'b1}};
      sdata_sync_r <= {SYNC_STAGES{1'b0}};
      cs_n_prev_r  <= 1'b1;
      sclk_prev_r  <= 1'b1;
      settle_r     <= 3'd0;
    end else begin
      cs_n_sync_r  <= {cs_n_sync_r[SYNC_STAGES-2:0], cs_n_in};
      sclk_sync_r  <= {sclk_sync_r[SYNC_STAGES-2:0], sclk_in};
      sdata_sync_r <= {sdata_sync_r[SYNC_STAGES-2:0], sdata_in};
      cs_n_prev_r  <= cs_n_s;
      sclk_prev_r  <= sclk_s;
      if (settle_r != SETTLE_DONE) begin
        settle_r <= settle_r + 3'd1;
      end
    end
  end

  // Edges are masked until the synchroniser has refilled from the pins, so a
  // cs_n held low across reset never looks like a fresh frame start.
  assign settled_s   = (settle_r == SETTLE_DONE);
  assign cs_fall_s   = settled_s & cs_n_prev_r & ~cs_n_s;
  assign cs_rise_s   = settled_s & ~cs_n_prev_r & cs_n_s;
  assign sclk_rise_s = settled_s & ~sclk_prev_r & sclk_s;

`ifdef LOADER_PARITY_EN
  assign frame_ok_s = (bit_cnt_r == FRAME_BITS_C) && !ovr_r && odd_parity_ok(shift_r);
`else
  assign frame_ok_s = (bit_cnt_r == FRAME_BITS_C) && !ovr_r;
`endif

  // Next-state decode.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cs_fall_s) state_nx = ST_SHIFT;
        else           state_nx = ST_IDLE;
      end
      ST_SHIFT: begin
        if (cs_rise_s) state_nx = frame_ok_s ? ST_HOLD : ST_IDLE;
        else           state_nx = ST_SHIFT;
      end
      ST_HOLD: begin
        if (load_bus.load_ready) state_nx = ST_IDLE;
        else                     state_nx = ST_HOLD;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // State, shift datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_r      <= ST_IDLE;
      bit_cnt_r    <= 4'd0;
      ovr_r        <= 1'b0;
      shift_r      <= {FRAME_BITS{1'b0}};
      load_data_r  <= 8'h00;
      load_valid_r <= 1'b0;
      busy_r       <= 1'b0;
      frame_err_r  <= 1'b0;
    end else begin
      state_r      <= state_nx;
      busy_r       <= (state_nx != ST_IDLE);
      load_valid_r <= (state_nx == ST_HOLD);
      frame_err_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (cs_fall_s) begin
            bit_cnt_r <= 4'd0;
            ovr_r     <= 1'b0;
          end
        end
        ST_SHIFT: begin
          // A cs rise takes priority and swallows any coincident sclk rise.
          if (cs_rise_s) begin
            if (frame_ok_s) load_data_r <= shift_r[FRAME_BITS-1 -: 8];
            else            frame_err_r <= 1'b1;
          end else if (sclk_rise_s) begin
            if (bit_cnt_r == FRAME_BITS_C) begin
              ovr_r <= 1'b1;
            end else begin
              shift_r   <= {shift_r[FRAME_BITS-2:0], sdata_s};
              bit_cnt_r <= bit_cnt_r + 4'd1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign load_bus.load_data  = load_data_r;
  assign load_bus.load_valid = load_valid_r;
  assign load_bus.busy       = busy_r;
  assign load_bus.frame_err  = frame_err_r;

endmodule

// File: tb/tb_counter_preload_loader.sv
// Scoreboard bench for counter_preload_loader: directed scenarios plus random
// frames, each outcome predicted from the frame length/parity rules.
module tb_counter_preload_loader;
  localparam int SS = 2;
`ifdef LOADER_PARITY_EN
  localparam int FB = 9;
`else
  localparam int FB = 8;
`endif

  typedef struct packed {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic cs_n_pin;
  logic sclk_pin;
  logic sdata_pin;
  logic ready_drv;
  bit   rand_ready;
  int   total;
  int   bad;
  logic [7:0] last_acc;
  exp_t exp_q[$];

  counter_preload_loader_if bus();
  assign bus.load_ready = ready_drv;

  counter_preload_loader #(.SYNC_STAGES(SS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cs_n_in  (cs_n_pin),
    .sclk_in  (sclk_pin),
    .sdata_in (sdata_pin),
    .load_bus (bus)
  );

  function automatic logic [15:0] make_frame(input logic [7:0] d);
`ifdef LOADER_PARITY_EN
    return {7'd0, d, ~(^d)};
`else
    return {8'h00, d};
`endif
  endfunction

  // Reference rule: exactly FB bits (and odd parity if enabled) is accepted,
  // the value being the first eight bits sent; anything else is rejected.
  function automatic exp_t predict(input logic [15:0] bits, input int n);
    exp_t e;
    logic [15:0] first8;
    e.is_err = 1'b1;
    e.data   = 8'h00;
    if (n == FB) begin
      first8   = bits >> (n - 8);
      e.data   = first8[7:0];
      e.is_err = 1'b0;
`ifdef LOADER_PARITY_EN
      if (($countones(bits[8:0]) % 2) == 0) e.is_err = 1'b1;
`endif
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_frame(input logic [15:0] bits, input int n, input bit coincide);
    cs_n_pin = 1'b0;
    wait_clks(4);
    for (int i = n - 1; i >= 0; i--) begin
      sdata_pin = bits[i];
      wait_clks(3);
      sclk_pin = 1'b1;
      wait_clks(3);
      sclk_pin = 1'b0;
    end
    wait_clks(3);
    if (coincide) sclk_pin = 1'b1;
    cs_n_pin = 1'b1;
    if (coincide) begin
      wait_clks(3);
      sclk_pin = 1'b0;
    end
  endtask

  task automatic issue(input logic [15:0] bits, input int n, input bit coincide);
    exp_q.push_back(predict(bits, n));
    send_frame(bits, n, coincide);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (bus.busy && k < 400) begin
      @(posedge clk);
      k++;
    end
    #2;
    if (k >= 400) begin
      total++;
      bad++;
      $display("FAIL wait_idle: busy still %0d after %0d cycles", bus.busy, k);
    end
  endtask

  initial begin
    int k;
    int vcnt;
    int r;
    int n;
    logic [15:0] bits;
    rst_n      = 1'b1;
    cs_n_pin   = 1'b1;
    sclk_pin   = 1'b0;
    sdata_pin  = 1'b0;
    ready_drv  = 1'b1;
    rand_ready = 1'b0;
    total      = 0;
    bad        = 0;
    last_acc   = 8'h00;

    fork
      begin : monitor
        exp_t e;
        forever begin
          @(negedge clk);
          if (rst_n) begin
            last_acc = 8'h00;
          end else begin
            if (bus.frame_err || (bus.load_valid && bus.load_ready)) begin
              if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: err=%0d valid=%0d data=%0h with empty queue",
                         bus.frame_err, bus.load_valid, bus.load_data);
              end else begin
                e = exp_q.pop_front();
                check("outcome_is_err", bus.frame_err, e.is_err);
                if (bus.frame_err) begin
                  check("err_data_kept", bus.load_data, last_acc);
                end else begin
                  check("load_data", bus.load_data, e.data);
                  last_acc = e.data;
                end
              end
            end
          end
        end
      end
      forever begin
        @(posedge clk);
        #2;
        if (rand_ready) ready_drv = 1'($urandom_range(0, 1));
      end
      begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
      end
    join_none

    // Reset values.
    wait_clks(3);
    @(negedge clk);
    check("rst_load_data", bus.load_data, 8'h00);
    check("rst_load_valid", bus.load_valid, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_frame_err", bus.frame_err, 1'b0);
    rst_n = 1'b0;
    wait_clks(8);

    // A5 with ready high: latency, single-cycle valid, busy drops.
    issue(make_frame(8'hA5), FB, 1'b0);
    k = 0;
    do begin
      @(posedge clk);
      k++;
      @(negedge clk);
    end while (!bus.load_valid && k < 20);
    check("pin_to_valid_latency", k, SS + 1);
    @(negedge clk);
    check("valid_one_cycle", bus.load_valid, 1'b0);
    wait_clks(4);
    check("busy_after_a5", bus.busy, 1'b0);
    wait_clks(4);

    // 3C held with ready low for 10 cycles; a frame started during HOLD is lost.
    ready_drv = 1'b0;
    issue(make_frame(8'h3C), FB, 1'b0);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.load_valid && k < 50);
    check("hold_valid_seen", bus.load_valid, 1'b1);
    vcnt = bus.load_valid ? 1 : 0;
    fork
      begin
        for (int c = 2; c <= 15; c++) begin
          @(posedge clk);
          #2;
          if (c == 11) ready_drv = 1'b1;
          @(negedge clk);
          if (bus.load_valid) begin
            vcnt++;
            check("hold_data_stable", bus.load_data, 8'h3C);
          end
        end
      end
      begin
        repeat (2) @(posedge clk);
        #3;
        send_frame(make_frame(8'h5A), FB, 1'b0);
      end
    join
    check("hold_valid_cycles", vcnt, 11);
    wait_clks(8);

    // Short and long frames are both rejected.
    issue(16'h0055, FB - 1, 1'b0);
    wait_clks(8);
    issue(16'h03AB, FB + 1, 1'b0);
    wait_clks(8);
    check("data_kept_after_errs", bus.load_data, 8'h3C);

    // FF with an sclk rise on the same cycle as cs rise.
    issue(make_frame(8'hFF), FB, 1'b1);
    wait_clks(8);

    // Reset mid-frame with cs held low, then a fresh frame.
    cs_n_pin = 1'b0;
    wait_clks(4);
    for (int i = 0; i < 4; i++) begin
      sdata_pin = 1'(i);
      wait_clks(3);
      sclk_pin = 1'b1;
      wait_clks(3);
      sclk_pin = 1'b0;
    end
    rst_n = 1'b1;
    wait_clks(2);
    @(negedge clk);
    check("midframe_rst_data", bus.load_data, 8'h00);
    rst_n = 1'b0;
    wait_clks(12);
    check("post_rst_busy", bus.busy, 1'b0);
    check("post_rst_valid", bus.load_valid, 1'b0);
    cs_n_pin = 1'b1;
    wait_clks(8);
    issue(make_frame(8'h01), FB, 1'b0);
    wait_clks(8);

`ifdef LOADER_PARITY_EN
    issue({7'd0, 8'h07, 1'b0}, 9, 1'b0);
    wait_clks(8);
    issue({7'd0, 8'h07, 1'b1}, 9, 1'b0);
    wait_clks(8);
`endif

    // Random frames with random downstream back-pressure.
    rand_ready = 1'b1;
    repeat (20) begin
      r = $urandom_range(0, 5);
      n = (r == 0) ? FB - 1 : ((r == 1) ? FB + 1 : FB);
      bits = (n == FB) ? make_frame(8'($urandom)) : 16'($urandom);
      if (r == 2) bits = bits ^ 16'h0001;
      issue(bits, n, ($urandom_range(0, 3) == 0));
      wait_clks(6);
      wait_idle();
      wait_clks(4);
    end
    rand_ready = 1'b0;
    ready_drv  = 1'b1;
    wait_clks(10);

    check("queue_drained", exp_q.size(), 0);
    check("final_valid", bus.load_valid, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
